// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM arbiter: FSM encoding and read-ID type.
package sdram_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_GNT0 = 2'd1;
  localparam state_t ST_GNT1 = 2'd2;

  typedef logic mid_t;

  localparam mid_t M0_ID = 1'b0;
  localparam mid_t M1_ID = 1'b1;

  function automatic state_t gnt_state(input mid_t id);
    return (id == M1_ID) ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/sdram_arbiter_2m_if.sv
// Avalon-MM port bundle; used for both master-facing ports and the slave-facing port.
interface sdram_arbiter_2m_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16
);

  logic [ADDR_W-1:0]   address;
  logic                read_n;
  logic                write_n;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read_n, write_n, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read_n, write_n, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sdram_rd_id_fifo.sv
// Synchronous FIFO of master IDs for outstanding reads; front ID steers returning data.
module sdram_rd_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  mid_t din,
  output mid_t front,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  mid_t          mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign front   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sdram_arbiter_2m.sv
// Two-master Avalon-MM arbiter onto one SDRAM slave with read-ID return routing.
// Define PRIORITY_M0_EN for fixed m0 priority instead of round-robin.
module sdram_arbiter_2m
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  sdram_arbiter_2m_if.slave   m0,
  sdram_arbiter_2m_if.slave   m1,
  sdram_arbiter_2m_if.master  s,
  output logic                s_chipselect,
  output logic                err_orphan
);

  state_t              state_q, state_d;
  logic                err_orphan_q;
  logic                req0, req1;
  logic                gnt_active;
  mid_t                sel;
  logic [ADDR_W-1:0]   addr_mux;
  logic [DATA_W-1:0]   wdata_mux;
  logic [DATA_W/8-1:0] be_mux;
  logic                rd_n_mux, wr_n_mux;
  logic                rd_cmd, wr_cmd, rd_block, accept, push, pop;
  logic                fifo_full, fifo_empty;
  mid_t                fifo_front;

  assign req0       = ~m0.read_n | ~m0.write_n;
  assign req1       = ~m1.read_n | ~m1.write_n;
  assign gnt_active = (state_q == ST_GNT0) | (state_q == ST_GNT1);
  assign sel        = (state_q == ST_GNT1) ? M1_ID : M0_ID;

  always_comb begin
    if (sel == M1_ID) begin
      addr_mux  = m1.address;
      wdata_mux = m1.writedata;
      be_mux    = m1.byteenable;
      rd_n_mux  = m1.read_n;
      wr_n_mux  = m1.write_n;
    end else begin
      addr_mux  = m0.address;
      wdata_mux = m0.writedata;
      be_mux    = m0.byteenable;
      rd_n_mux  = m0.read_n;
      wr_n_mux  = m0.write_n;
    end
  end

  // Read and write both asserted is treated as a read.
  assign rd_cmd   = gnt_active & ~rd_n_mux;
  assign wr_cmd   = gnt_active & rd_n_mux & ~wr_n_mux;
  assign rd_block = rd_cmd & fifo_full;
  assign accept   = gnt_active & ~s.waitrequest & ~rd_block;
  assign push     = accept & rd_cmd;
  assign pop      = s.readdatavalid & ~fifo_empty;

  sdram_rd_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rd_id_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (sel),
    .front   (fifo_front),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef PRIORITY_M0_EN
  mid_t tie_winner;
  assign tie_winner = M0_ID;
`else
  mid_t last_gnt_q, tie_winner;
  assign tie_winner = ~last_gnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n)    last_gnt_q <= M1_ID;
    else if (accept) last_gnt_q <= sel;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) state_d = gnt_state(tie_winner);
        else if (req0)    state_d = ST_GNT0;
        else if (req1)    state_d = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        if (accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      err_orphan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (s.readdatavalid && fifo_empty) err_orphan_q <= 1'b1;
    end
  end

  // Reset is synchronous, so outputs are gated directly to stay quiet during the reset cycle.
  assign s.address        = addr_mux;
  assign s.writedata      = wdata_mux;
  assign s.byteenable     = be_mux;
  assign s.read_n         = ~(reset_n & rd_cmd & ~fifo_full);
  assign s.write_n        = ~(reset_n & wr_cmd);
  assign s_chipselect     = reset_n & gnt_active;

  assign m0.waitrequest   = ~(reset_n & accept & (state_q == ST_GNT0));
  assign m1.waitrequest   = ~(reset_n & accept & (state_q == ST_GNT1));
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = reset_n & pop & (fifo_front == M0_ID);
  assign m1.readdatavalid = reset_n & pop & (fifo_front == M1_ID);

  assign err_orphan       = err_orphan_q;

endmodule
